// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg
//  Shared types and constants for the reset sequencer.
//  - state_t   : sequencer FSM states
//  - MON_DIV_W : width of the clk_mon-domain divider whose MSB is monitored
//  - max_int   : helper used to size the shared cycle counter
package rst_seq_pkg;

  typedef enum logic [2:0] {
    HOLD,
    STABLE,
    STAGE,
    RUN,
    FAULT
  } state_t;

  localparam int MON_DIV_W = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_seq_clkmon.sv
// rst_seq_clkmon
//  Activity monitor for the second PLL output. A small free-running divider
//  runs on clk_mon; its MSB is brought into clk_out0 through a 2-FF
//  synchroniser and every toggle of the synced MSB restarts a saturating
//  timeout counter. Only built when RST_SEQ_CLKMON_EN is defined.
// Ports
//  clk_out0    in   sequencer clock
//  arst_n      in   asynchronous active-low reset (clears both clock domains)
//  clk_mon     in   monitored clock
//  mon_en      in   1 = count towards a timeout; 0 = hold the timeout counter at zero
//  mon_edge    out  1 = synced divider MSB toggled this cycle
//  mon_timeout out  1 = no activity for MON_TIMEOUT clk_out0 cycles
module rst_seq_clkmon
  import rst_seq_pkg::*;
#(
  parameter int MON_TIMEOUT = 64
) (
  input  logic clk_out0,
  input  logic arst_n,
  input  logic clk_mon,
  input  logic mon_en,
  output logic mon_edge,
  output logic mon_timeout
);

  localparam int TW = $clog2(MON_TIMEOUT + 1);

  logic [MON_DIV_W-1:0] div_q, div_d;
  logic [2:0]           msb_sync_q, msb_sync_d;
  logic [TW-1:0]        tmo_q, tmo_d;

  always_comb begin
    div_d = div_q + MON_DIV_W'(1);
  end

  always_ff @(posedge clk_mon or negedge arst_n) begin
    if (!arst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // Bits [1:0] are the synchroniser, bit [2] keeps the previous synced value
  // so a toggle in either direction counts as activity.
  always_comb begin
    msb_sync_d = {msb_sync_q[1:0], div_q[MON_DIV_W-1]};
  end

  assign mon_edge = msb_sync_q[2] ^ msb_sync_q[1];

  // Saturates at MON_TIMEOUT so a stopped clock keeps reporting a timeout.
  always_comb begin
    tmo_d = tmo_q;
    if (!mon_en || mon_edge) begin
      tmo_d = '0;
    end else if (tmo_q != TW'(MON_TIMEOUT)) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  assign mon_timeout = (tmo_q == TW'(MON_TIMEOUT));

  always_ff @(posedge clk_out0 or negedge arst_n) begin
    if (!arst_n) begin
      msb_sync_q <= '0;
      tmo_q      <= '0;
    end else begin
      msb_sync_q <= msb_sync_d;
      tmo_q      <= tmo_d;
    end
  end

endmodule

// File: rtl/rst_seq_top.sv
// rst_seq_top
//  Reset sequencer downstream of the top-level PLL. The PLL-qualified async
//  reset is released through a 2-FF synchroniser, then after STABLE_CYC cycles
//  the per-domain resets are released one at a time, STAGE_GAP cycles apart,
//  bit 0 first. A software request puts every domain back into reset and
//  restarts the whole sequence.
//  Optional feature (macro RST_SEQ_CLKMON_EN): monitor clk_mon and force all
//  domains back into reset if it stops; fault_sticky records the event.
// Ports
//  clk_out0     in   sequencer clock
//  arst_n       in   asynchronous active-low reset
//  clk_mon      in   monitored clock (ignored without RST_SEQ_CLKMON_EN)
//  sw_rst_req   in   level: hold everything in reset and rerun the sequence
//  fault_clr    in   pulse: clear fault_sticky
//  rst_n_out    out  per-stage active-low resets, bit 0 released first
//  seq_done     out  1 = all stages released
//  fault_sticky out  1 = clk_mon timeout seen since last clear (0 without the macro)
module rst_seq_top
  import rst_seq_pkg::*;
#(
  parameter int N_STAGE     = 3,
  parameter int STABLE_CYC  = 1024,
  parameter int STAGE_GAP   = 64,
  parameter int MON_TIMEOUT = 64
) (
  input  logic               clk_out0,
  input  logic               arst_n,
  input  logic               clk_mon,
  input  logic               sw_rst_req,
  input  logic               fault_clr,
  output logic [N_STAGE-1:0] rst_n_out,
  output logic               seq_done,
  output logic               fault_sticky
);

  localparam int CW = $clog2(max_int(STABLE_CYC, STAGE_GAP) + 1);
  localparam int IW = $clog2(N_STAGE + 1);

  logic [1:0]         sync_q, sync_d;
  logic               rst_sync_n;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [N_STAGE-1:0] rst_q, rst_d;
  logic               done_q, done_d;

  // Async assert, sync de-assert: the FSM only sees the release two edges
  // after arst_n rises.
  always_comb begin
    sync_d = {sync_q[0], 1'b1};
  end

  always_ff @(posedge clk_out0 or negedge arst_n) begin
    if (!arst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rst_sync_n = sync_q[1];

`ifdef RST_SEQ_CLKMON_EN
  logic mon_en;
  logic mon_edge;
  logic mon_timeout;
  logic fault_sticky_q, fault_sticky_d;

  assign mon_en = (state_q == STABLE) || (state_q == STAGE) || (state_q == RUN);

  rst_seq_clkmon #(
    .MON_TIMEOUT(MON_TIMEOUT)
  ) u_clkmon (
    .clk_out0   (clk_out0),
    .arst_n     (arst_n),
    .clk_mon    (clk_mon),
    .mon_en     (mon_en),
    .mon_edge   (mon_edge),
    .mon_timeout(mon_timeout)
  );
`else
  logic unused_inputs;
  assign unused_inputs = clk_mon ^ fault_clr ^ (MON_TIMEOUT == 0);
`endif

  // cnt counts cycles inside STABLE and between stage releases; idx is the
  // index of the next stage bit to release.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    done_d  = done_q;

    case (state_q)
      HOLD: begin
        rst_d  = '0;
        done_d = 1'b0;
        cnt_d  = '0;
        idx_d  = '0;
        if (rst_sync_n && !sw_rst_req) begin
          state_d = STABLE;
        end
      end
      STABLE: begin
        if (cnt_q == CW'(STABLE_CYC - 1)) begin
          cnt_d    = '0;
          rst_d[0] = 1'b1;
          idx_d    = IW'(1);
          if (N_STAGE == 1) begin
            state_d = RUN;
            done_d  = 1'b1;
          end else begin
            state_d = STAGE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STAGE: begin
        if (cnt_q == CW'(STAGE_GAP - 1)) begin
          cnt_d = '0;
          for (int k = 0; k < N_STAGE; k++) begin
            if (idx_q == IW'(k)) begin
              rst_d[k] = 1'b1;
            end
          end
          idx_d = idx_q + IW'(1);
          if (idx_q == IW'(N_STAGE - 1)) begin
            state_d = RUN;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN: begin
        cnt_d = '0;
      end
      FAULT: begin
`ifdef RST_SEQ_CLKMON_EN
        if (mon_edge) begin
          state_d = HOLD;
        end
`else
        state_d = HOLD;
`endif
      end
      default: begin
        state_d = HOLD;
      end
    endcase

    // Software request beats everything else and releases nothing until it drops.
    if (sw_rst_req && (state_q != HOLD)) begin
      state_d = HOLD;
      rst_d   = '0;
      done_d  = 1'b0;
      cnt_d   = '0;
      idx_d   = '0;
    end
`ifdef RST_SEQ_CLKMON_EN
    else if (mon_en && mon_timeout) begin
      state_d = FAULT;
      rst_d   = '0;
      done_d  = 1'b0;
      cnt_d   = '0;
      idx_d   = '0;
    end
`endif
  end

  always_ff @(posedge clk_out0 or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
    end
  end

`ifdef RST_SEQ_CLKMON_EN
  // A new fault on the same edge as fault_clr leaves the flag set.
  always_comb begin
    fault_sticky_d = fault_sticky_q;
    if (fault_clr) begin
      fault_sticky_d = 1'b0;
    end
    if ((state_d == FAULT) && (state_q != FAULT)) begin
      fault_sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk_out0 or negedge arst_n) begin
    if (!arst_n) begin
      fault_sticky_q <= 1'b0;
    end else begin
      fault_sticky_q <= fault_sticky_d;
    end
  end

  assign fault_sticky = fault_sticky_q;
`else
  assign fault_sticky = 1'b0;
`endif

  assign rst_n_out = rst_q;
  assign seq_done  = done_q;

endmodule

// File: tb/tb_rst_seq_top.sv
// tb_rst_seq_top
//  Self-checking bench for rst_seq_top (N_STAGE=3, STABLE_CYC=16, STAGE_GAP=4,
//  MON_TIMEOUT=64). A behavioural model predicts the reset outputs from the
//  number of clk_out0 edges since arst_n release and the sampled sw_rst_req.
//  Monitor scenarios are compiled in when RST_SEQ_CLKMON_EN is defined.
module tb_rst_seq_top;

  localparam int N_STAGE     = 3;
  localparam int STABLE_CYC  = 16;
  localparam int STAGE_GAP   = 4;
  localparam int MON_TIMEOUT = 64;

  logic               clk_out0;
  logic               arst_n;
  logic               clk_mon;
  logic               sw_rst_req;
  logic               fault_clr;
  logic [N_STAGE-1:0] rst_n_out;
  logic               seq_done;
  logic               fault_sticky;
  logic               clk_mon_run;

  int errors;
  int checks;

  // Model state: edges since arst_n release, whether the domains are held,
  // and the edge at which the current sequence started.
  int rel_edge;
  bit idle;
  int origin;

  rst_seq_top #(
    .N_STAGE    (N_STAGE),
    .STABLE_CYC (STABLE_CYC),
    .STAGE_GAP  (STAGE_GAP),
    .MON_TIMEOUT(MON_TIMEOUT)
  ) dut (
    .clk_out0    (clk_out0),
    .arst_n      (arst_n),
    .clk_mon     (clk_mon),
    .sw_rst_req  (sw_rst_req),
    .fault_clr   (fault_clr),
    .rst_n_out   (rst_n_out),
    .seq_done    (seq_done),
    .fault_sticky(fault_sticky)
  );

  initial clk_out0 = 1'b0;
  always #5 clk_out0 = ~clk_out0;

  initial clk_mon = 1'b0;
  always #6 clk_mon = clk_mon_run ? ~clk_mon : 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [N_STAGE-1:0] modelRst();
    logic [N_STAGE-1:0] r;
    r = '0;
    if (!idle) begin
      for (int k = 0; k < N_STAGE; k++) begin
        if (rel_edge >= origin + STABLE_CYC + k * STAGE_GAP) r[k] = 1'b1;
      end
    end
    return r;
  endfunction

  // One clk_out0 edge: advance the model with the inputs seen at the edge,
  // then compare shortly after the edge.
  task automatic tickModel();
    logic               sw_s;
    logic [N_STAGE-1:0] exp_rst;
    sw_s = sw_rst_req;
    @(posedge clk_out0);
    if (arst_n) begin
      rel_edge++;
      if (rel_edge < 3) begin
        idle = 1'b1;
      end else if (idle) begin
        if (!sw_s) begin
          idle   = 1'b0;
          origin = rel_edge;
        end
      end else if (sw_s) begin
        idle = 1'b1;
      end
    end
    #1;
    exp_rst = modelRst();
    checkOutput("rst_n_out", 32'(rst_n_out), 32'(exp_rst));
    checkOutput("seq_done", 32'(seq_done), 32'(exp_rst == '1));
    checkOutput("fault_sticky", 32'(fault_sticky), 32'd0);
  endtask

  task automatic applyStimulus(input logic sw, input int cycles);
    sw_rst_req = sw;
    for (int i = 0; i < cycles; i++) tickModel();
  endtask

  // Short arst_n low pulse between edges; outputs must clear with no clock.
  task automatic pulseArst();
    #1 arst_n = 1'b0;
    #1;
    checkOutput("arst_async_rst", 32'(rst_n_out), 32'd0);
    checkOutput("arst_async_done", 32'(seq_done), 32'd0);
    rel_edge = 0;
    idle     = 1'b1;
    #2 arst_n = 1'b1;
  endtask

  // Walk edges after a release, with fixed-edge spot checks from the sequence timing.
  task automatic runRelease(input int n_edges);
    sw_rst_req = 1'b0;
    for (int e = 0; e < n_edges; e++) begin
      tickModel();
      case (rel_edge)
        18: checkOutput("edge18", 32'(rst_n_out), 32'b000);
        19: checkOutput("edge19", 32'(rst_n_out), 32'b001);
        22: checkOutput("edge22", 32'(rst_n_out), 32'b001);
        23: checkOutput("edge23", 32'(rst_n_out), 32'b011);
        26: checkOutput("edge26", 32'(rst_n_out), 32'b011);
        27: begin
          checkOutput("edge27", 32'(rst_n_out), 32'b111);
          checkOutput("edge27_done", 32'(seq_done), 32'd1);
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  r;
    bit  found;
    errors      = 0;
    checks      = 0;
    rel_edge    = 0;
    idle        = 1'b1;
    origin      = 0;
    arst_n      = 1'b0;
    sw_rst_req  = 1'b0;
    fault_clr   = 1'b0;
    clk_mon_run = 1'b1;

    #12;
    checkOutput("reset_rst_n_out", 32'(rst_n_out), 32'd0);
    checkOutput("reset_seq_done", 32'(seq_done), 32'd0);
    checkOutput("reset_fault", 32'(fault_sticky), 32'd0);

    @(posedge clk_out0);
    #1 arst_n = 1'b1;
    $display("[TB] release timing");
    runRelease(20);
    checkOutput("mid_stage_001", 32'(rst_n_out), 32'b001);
    pulseArst();
    $display("[TB] re-release after mid-stage arst pulse");
    runRelease(30);

    $display("[TB] software reset in RUN");
    applyStimulus(1'b1, 5);
    sw_rst_req = 1'b0;
    for (int i = 1; i <= STABLE_CYC + 1; i++) begin
      tickModel();
      if (i == STABLE_CYC) checkOutput("sw_bit0_before", 32'(rst_n_out[0]), 32'd0);
      if (i == STABLE_CYC + 1) checkOutput("sw_bit0_release", 32'(rst_n_out[0]), 32'd1);
    end
    applyStimulus(1'b0, 12);

    $display("[TB] randomized stimulus");
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        pulseArst();
        applyStimulus(1'b0, $urandom_range(1, 10));
      end else if (r < 4) begin
        applyStimulus(1'b1, $urandom_range(1, 6));
      end else begin
        applyStimulus(1'b0, $urandom_range(1, 40));
      end
    end
    applyStimulus(1'b0, 60);
    checkOutput("run_before_mon", 32'(seq_done), 32'd1);

`ifdef RST_SEQ_CLKMON_EN
    $display("[TB] clk_mon stop in RUN");
    clk_mon_run = 1'b0;
    found = 1'b0;
    // Allows for a toggle still in the synchroniser, the full timeout and the FAULT edge.
    for (int i = 0; i < MON_TIMEOUT + 8 && !found; i++) begin
      @(posedge clk_out0);
      #1;
      if (rst_n_out == '0) found = 1'b1;
    end
    checkOutput("mon_fault_seen", 32'(found), 32'd1);
    checkOutput("mon_fault_rst", 32'(rst_n_out), 32'd0);
    checkOutput("mon_fault_done", 32'(seq_done), 32'd0);
    checkOutput("mon_fault_sticky", 32'(fault_sticky), 32'd1);

    clk_mon_run = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(posedge clk_out0);
      #1;
      if (seq_done) found = 1'b1;
    end
    checkOutput("mon_reseq_done", 32'(found), 32'd1);
    checkOutput("mon_reseq_rst", 32'(rst_n_out), 32'b111);
    checkOutput("mon_sticky_kept", 32'(fault_sticky), 32'd1);

    fault_clr = 1'b1;
    @(posedge clk_out0);
    #1 fault_clr = 1'b0;
    checkOutput("fault_clr", 32'(fault_sticky), 32'd0);

    $display("[TB] fault_clr held across a new timeout");
    fault_clr   = 1'b1;
    clk_mon_run = 1'b0;
    found = 1'b0;
    for (int i = 0; i < MON_TIMEOUT + 8 && !found; i++) begin
      @(posedge clk_out0);
      #1;
      if (rst_n_out == '0) begin
        found = 1'b1;
        checkOutput("set_wins_sticky", 32'(fault_sticky), 32'd1);
      end
    end
    checkOutput("set_wins_seen", 32'(found), 32'd1);
    fault_clr   = 1'b0;
    clk_mon_run = 1'b1;
`else
    $display("[TB] clk_mon held low in RUN, monitor absent");
    clk_mon_run = 1'b0;
    applyStimulus(1'b0, 1000);
    checkOutput("no_mon_rst", 32'(rst_n_out), 32'b111);
    checkOutput("no_mon_fault", 32'(fault_sticky), 32'd0);
    clk_mon_run = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
